// File: rtl/ahb_sram_64_pkg.sv
// Shared constants and bus encodings for the 64-bit AHB-Lite SRAM slave.
package ahb_sram_64_pkg;

    localparam int AW        = 32;
    localparam int DW        = 64;
    localparam int SRAM_AW   = 10;
    localparam int NUM_LANES = 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_8    = 3'd0,
        HSIZE_16   = 3'd1,
        HSIZE_32   = 3'd2,
        HSIZE_64   = 3'd3,
        HSIZE_128  = 3'd4,
        HSIZE_256  = 3'd5,
        HSIZE_512  = 3'd6,
        HSIZE_1024 = 3'd7
    } hsize_t;

endpackage

// File: rtl/ahb_sram_bytemask.sv
// Byte-lane mask for a transfer of a given size at a given offset within the doubleword.
module ahb_sram_bytemask
    import ahb_sram_64_pkg::*;
(
    input  logic [2:0]           hsize,
    input  logic [2:0]           addr_lo,
    output logic [NUM_LANES-1:0] mask
);

    // Decode size and low address bits into the lanes the transfer touches.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
        mask = '1;
        case (hsize_t'(hsize))
            HSIZE_8:  mask = 8'h01 << addr_lo;
            HSIZE_16: mask = 8'h03 << {addr_lo[2:1], 1'b0};
            HSIZE_32: mask = 8'h0F << {addr_lo[2], 2'b00};
            default:  mask = '1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_64.sv
// Zero-wait-state AHB-Lite slave in front of a 1024 x 64-bit synchronous SRAM.
// Writes go through a one-entry buffer that drains on the next cycle without a read;
// reads that hit the undrained buffer get the buffered lanes forwarded.
module ahb_sram_64 #(
    parameter int AW      = ahb_sram_64_pkg::AW,
    parameter int DW      = ahb_sram_64_pkg::DW,
    parameter int SRAM_AW = ahb_sram_64_pkg::SRAM_AW
) (
    input  logic                                   HCLK,
    input  logic                                   HRESETn,
    input  logic                                   HSEL,
    input  logic [AW-1:0]                          HADDR,
    input  logic                                   HREADY,
    input  logic                                   HWRITE,
    input  logic [1:0]                             HTRANS,
    input  logic [2:0]                             HSIZE,
    input  logic [DW-1:0]                          HWDATA,
    output logic [DW-1:0]                          HRDATA,
    output logic                                   HREADYOUT,
    input  logic [DW-1:0]                          SRAMRDATA,
    output logic [ahb_sram_64_pkg::NUM_LANES-1:0]  SRAMWEN,
    output logic [DW-1:0]                          SRAMWDATA,
    output logic                                   SRAMCS0,
    output logic [SRAM_AW-1:0]                     SRAMADDR
);

    import ahb_sram_64_pkg::*;

    logic                 acc, rd, wr;
    logic [NUM_LANES-1:0] mask;
    logic [SRAM_AW-1:0]   req_addr;

    logic [SRAM_AW-1:0]   buf_addr;
    logic [NUM_LANES-1:0] buf_we;
    logic [DW-1:0]        buf_data, buf_data_nxt;
    logic                 buf_data_en, buf_pend;
    logic [NUM_LANES-1:0] hit_mask;
    logic                 pending, drain;

    // Upper address bits alias every 8 KB; HTRANS[0] only separates NONSEQ/SEQ and IDLE/BUSY.
    logic unused_bits;
    assign unused_bits = ^{HADDR[AW-1:SRAM_AW+3], HTRANS[0]};

    assign acc      = HSEL & HREADY & HTRANS[1];
    assign rd       = acc & ~HWRITE;
    assign wr       = acc & HWRITE;
    assign req_addr = HADDR[SRAM_AW+2:3];
    assign pending  = buf_pend | buf_data_en;
    assign drain    = pending & ~rd;

    assign HREADYOUT = 1'b1;

    ahb_sram_bytemask u_bytemask (
        .hsize   (HSIZE),
        .addr_lo (HADDR[2:0]),
        .mask    (mask)
    );

    // Merge the write data-phase lanes into the buffered doubleword.
    always_comb begin
        buf_data_nxt = buf_data;
        if (buf_data_en) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (buf_we[i]) buf_data_nxt[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // Write buffer and forwarding-mask state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        // NOTE: the buffer is a handful of flops, so it is fully reset; the SRAM macro behind it has no reset and a pending write is simply dropped.
        if (!HRESETn) begin
            buf_addr    <= '0;
            buf_we      <= '0;
            buf_data    <= '0;
            buf_data_en <= 1'b0;
            buf_pend    <= 1'b0;
            hit_mask    <= '0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            if (wr) begin
                buf_addr <= req_addr;
                buf_we   <= mask;
            end
            buf_data_en <= wr;
            if (buf_data_en) buf_data <= buf_data_nxt;
            if (drain)            buf_pend <= 1'b0;
            else if (buf_data_en) buf_pend <= 1'b1;
            hit_mask <= (rd && pending && (req_addr == buf_addr)) ? buf_we : '0;
        end
    end

    // SRAM port: reads take priority, otherwise a pending write drains.
    always_comb begin
        SRAMCS0   = 1'b0;
        SRAMADDR  = buf_addr;
        SRAMWEN   = '0;
        SRAMWDATA = buf_data_nxt;
        if (rd) begin
            SRAMCS0  = 1'b1;
            SRAMADDR = req_addr;
        end else if (pending) begin
            SRAMCS0 = 1'b1;
            SRAMWEN = buf_we;
        end
    end

    // Read data: forwarded buffer lanes override the SRAM output.
    always_comb begin
        HRDATA = SRAMRDATA;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (hit_mask[i]) HRDATA[8*i +: 8] = buf_data[8*i +: 8];
        end
    end

endmodule

// File: tb/tb_ahb_sram_64.sv
// Directed bench for ahb_sram_64 with a behavioural SRAM model.
module tb_ahb_sram_64;

    import ahb_sram_64_pkg::*;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL    = 1'b0;
    logic [31:0] HADDR   = '0;
    logic        HREADY  = 1'b1;
    logic        HWRITE  = 1'b0;
    logic [1:0]  HTRANS  = HTRANS_IDLE;
    logic [2:0]  HSIZE   = '0;
    logic [63:0] HWDATA  = '0;
    logic [63:0] HRDATA;
    logic        HREADYOUT;
    logic [7:0]  SRAMWEN;
    logic [63:0] SRAMWDATA;
    logic        SRAMCS0;
    logic [9:0]  SRAMADDR;

    logic [63:0] mem [0:1023];
    logic [63:0] sram_rdata = 64'hDEAD_BEEF_0123_4567;
    int          wen_cnt = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 HCLK = ~HCLK;

    ahb_sram_64 dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HREADY    (HREADY),
        .HWRITE    (HWRITE),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADYOUT (HREADYOUT),
        .SRAMRDATA (sram_rdata),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMADDR  (SRAMADDR)
    );

    // Synchronous SRAM macro: byte-enabled write, registered read.
    always @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN != 8'h00) begin
                for (int i = 0; i < 8; i++)
                    if (SRAMWEN[i]) mem[SRAMADDR][8*i +: 8] <= SRAMWDATA[8*i +: 8];
                wen_cnt <= wen_cnt + 1;
            end else begin
                sram_rdata <= mem[SRAMADDR];
            end
        end
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic wr_en, input logic [31:0] a, input logic [2:0] sz);
        HSEL   = 1'b1;
        HREADY = 1'b1;
        HTRANS = HTRANS_NONSEQ;
        HWRITE = wr_en;
        HADDR  = a;
        HSIZE  = sz;
    endtask

    task automatic drive_idle();
        HSEL   = 1'b0;
        HREADY = 1'b1;
        HTRANS = HTRANS_IDLE;
        HWRITE = 1'b0;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [2:0] sz, input logic [63:0] d);
        tick();
        drive(1'b1, a, sz);
        tick();
        HWDATA = d;
        drive_idle();
        tick();
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        drive_idle();
        repeat (2) tick();
        #1;
        n_checks++; if (SRAMCS0 !== 1'b0) $display("FAIL reset_cs got=%h exp=0", SRAMCS0); else n_pass++;
        n_checks++; if (SRAMWEN !== 8'h00) $display("FAIL reset_wen got=%h exp=00", SRAMWEN); else n_pass++;
        n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL reset_hreadyout got=%h exp=1", HREADYOUT); else n_pass++;
        n_checks++; if (HRDATA !== 64'hDEAD_BEEF_0123_4567) $display("FAIL reset_hrdata got=%h exp=deadbeef01234567", HRDATA); else n_pass++;
        HRESETn = 1'b1;
    endtask

    task automatic test_dword_write();
        tick();
        drive(1'b1, 32'h100, HSIZE_64);
        #1;
        n_checks++; if (SRAMCS0 !== 1'b0) $display("FAIL dword_addr_cs got=%h exp=0", SRAMCS0); else n_pass++;
        tick();
        HWDATA = 64'h1122_3344_5566_7788;
        drive_idle();
        #1;
        n_checks++; if (SRAMCS0 !== 1'b1) $display("FAIL dword_drain_cs got=%h exp=1", SRAMCS0); else n_pass++;
        n_checks++; if (SRAMADDR !== 10'h020) $display("FAIL dword_drain_addr got=%h exp=020", SRAMADDR); else n_pass++;
        n_checks++; if (SRAMWEN !== 8'hFF) $display("FAIL dword_drain_wen got=%h exp=ff", SRAMWEN); else n_pass++;
        n_checks++; if (SRAMWDATA !== 64'h1122_3344_5566_7788) $display("FAIL dword_drain_wdata got=%h exp=1122334455667788", SRAMWDATA); else n_pass++;
        tick();
        #1;
        n_checks++; if (SRAMCS0 !== 1'b0) $display("FAIL dword_idle_cs got=%h exp=0", SRAMCS0); else n_pass++;
        drive(1'b0, 32'h100, HSIZE_64);
        #1;
        n_checks++; if (SRAMCS0 !== 1'b1 || SRAMWEN !== 8'h00) $display("FAIL dword_read_strobe got=cs%h/wen%h exp=cs1/wen00", SRAMCS0, SRAMWEN); else n_pass++;
        n_checks++; if (SRAMADDR !== 10'h020) $display("FAIL dword_read_addr got=%h exp=020", SRAMADDR); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 64'h1122_3344_5566_7788) $display("FAIL dword_read_data got=%h exp=1122334455667788", HRDATA); else n_pass++;
    endtask

    task automatic test_byte_write();
        bus_write(32'h100, HSIZE_64, 64'h0);
        drive(1'b1, 32'h105, HSIZE_8);
        tick();
        // Non-target lanes carry junk that must not reach the SRAM.
        HWDATA = 64'h1111_AB11_1111_1111;
        drive_idle();
        #1;
        n_checks++; if (SRAMWEN !== 8'h20) $display("FAIL byte_drain_wen got=%h exp=20", SRAMWEN); else n_pass++;
        n_checks++; if (SRAMWDATA[47:40] !== 8'hAB) $display("FAIL byte_drain_lane got=%h exp=ab", SRAMWDATA[47:40]); else n_pass++;
        tick();
        drive(1'b0, 32'h100, HSIZE_64);
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 64'h0000_AB00_0000_0000) $display("FAIL byte_read_data got=%h exp=0000ab0000000000", HRDATA); else n_pass++;
    endtask

    task automatic test_forward();
        bus_write(32'h208, HSIZE_64, 64'h0123_4567_89AB_CDEF);
        // Word write to the upper half of doubleword 0x41, then an immediate read.
        drive(1'b1, 32'h20C, HSIZE_32);
        tick();
        HWDATA = 64'hFFFF_FFFF_0000_0000;
        drive(1'b0, 32'h208, HSIZE_64);
        #1;
        n_checks++; if (SRAMCS0 !== 1'b1 || SRAMWEN !== 8'h00) $display("FAIL fwd_read_strobe got=cs%h/wen%h exp=cs1/wen00", SRAMCS0, SRAMWEN); else n_pass++;
        n_checks++; if (SRAMADDR !== 10'h041) $display("FAIL fwd_read_addr got=%h exp=041", SRAMADDR); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 64'hFFFF_FFFF_89AB_CDEF) $display("FAIL fwd_read_data got=%h exp=ffffffff89abcdef", HRDATA); else n_pass++;
        n_checks++; if (SRAMWEN !== 8'hF0) $display("FAIL fwd_drain_wen got=%h exp=f0", SRAMWEN); else n_pass++;
        n_checks++; if (SRAMADDR !== 10'h041) $display("FAIL fwd_drain_addr got=%h exp=041", SRAMADDR); else n_pass++;
        n_checks++; if (SRAMWDATA[63:32] !== 32'hFFFF_FFFF) $display("FAIL fwd_drain_wdata got=%h exp=ffffffff", SRAMWDATA[63:32]); else n_pass++;
        tick();
        drive(1'b0, 32'h208, HSIZE_64);
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 64'hFFFF_FFFF_89AB_CDEF) $display("FAIL fwd_sram_data got=%h exp=ffffffff89abcdef", HRDATA); else n_pass++;
    endtask

    task automatic test_back_to_back();
        tick();
        drive(1'b1, 32'h0, HSIZE_64);
        tick();
        HWDATA = 64'hA5A5_0001_A5A5_0002;
        drive(1'b1, 32'h8, HSIZE_64);
        #1;
        n_checks++; if (SRAMWEN !== 8'hFF || SRAMADDR !== 10'h000) $display("FAIL b2b_drain1 got=wen%h/addr%h exp=wenff/addr000", SRAMWEN, SRAMADDR); else n_pass++;
        n_checks++; if (SRAMWDATA !== 64'hA5A5_0001_A5A5_0002) $display("FAIL b2b_wdata1 got=%h exp=a5a50001a5a50002", SRAMWDATA); else n_pass++;
        tick();
        HWDATA = 64'h5A5A_0003_5A5A_0004;
        drive_idle();
        #1;
        n_checks++; if (SRAMWEN !== 8'hFF || SRAMADDR !== 10'h001) $display("FAIL b2b_drain2 got=wen%h/addr%h exp=wenff/addr001", SRAMWEN, SRAMADDR); else n_pass++;
        n_checks++; if (SRAMWDATA !== 64'h5A5A_0003_5A5A_0004) $display("FAIL b2b_wdata2 got=%h exp=5a5a00035a5a0004", SRAMWDATA); else n_pass++;
        tick();
        drive(1'b0, 32'h0, HSIZE_64);
        tick();
        drive(1'b0, 32'h8, HSIZE_64);
        #1;
        n_checks++; if (HRDATA !== 64'hA5A5_0001_A5A5_0002) $display("FAIL b2b_read1 got=%h exp=a5a50001a5a50002", HRDATA); else n_pass++;
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 64'h5A5A_0003_5A5A_0004) $display("FAIL b2b_read2 got=%h exp=5a5a00035a5a0004", HRDATA); else n_pass++;
    endtask

    task automatic test_no_access();
        for (int k = 0; k < 4; k++) begin
            tick();
            drive(1'b1, 32'h300, HSIZE_64);
            case (k)
                0: HSEL   = 1'b0;
                1: HTRANS = HTRANS_IDLE;
                2: HTRANS = HTRANS_BUSY;
                default: HREADY = 1'b0;
            endcase
            #1;
            n_checks++; if (SRAMCS0 !== 1'b0 || SRAMWEN !== 8'h00) $display("FAIL noacc_addr_%0d got=cs%h/wen%h exp=cs0/wen00", k, SRAMCS0, SRAMWEN); else n_pass++;
            tick();
            HWDATA = 64'hCAFE_CAFE_CAFE_CAFE;
            drive_idle();
            #1;
            n_checks++; if (SRAMCS0 !== 1'b0 || SRAMWEN !== 8'h00) $display("FAIL noacc_data_%0d got=cs%h/wen%h exp=cs0/wen00", k, SRAMCS0, SRAMWEN); else n_pass++;
        end
    endtask

    task automatic test_reset_pending();
        int wen_base;
        bus_write(32'h300, HSIZE_64, 64'h0F0E_0D0C_0B0A_0908);
        wen_base = wen_cnt;
        drive(1'b1, 32'h300, HSIZE_64);
        tick();
        HRESETn = 1'b0;
        HWDATA  = 64'hFFFF_FFFF_FFFF_FFFF;
        drive_idle();
        #1;
        n_checks++; if (SRAMCS0 !== 1'b0 || SRAMWEN !== 8'h00) $display("FAIL rstpend_strobe got=cs%h/wen%h exp=cs0/wen00", SRAMCS0, SRAMWEN); else n_pass++;
        repeat (2) tick();
        HRESETn = 1'b1;
        tick();
        drive(1'b0, 32'h300, HSIZE_64);
        tick();
        drive_idle();
        #1;
        n_checks++; if (HRDATA !== 64'h0F0E_0D0C_0B0A_0908) $display("FAIL rstpend_read got=%h exp=0f0e0d0c0b0a0908", HRDATA); else n_pass++;
        n_checks++; if (wen_cnt !== wen_base) $display("FAIL rstpend_wen_count got=%0d exp=%0d", wen_cnt, wen_base); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_dword_write();
        test_byte_write();
        test_forward();
        test_back_to_back();
        test_no_access();
        test_reset_pending();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
